stream_upsizer: RTL and testbench



---
 rtl/stream_pkg.sv | 15 +
 rtl/stream_upsizer.sv | 83 ++++++++
 tb/tb_stream_upsizer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_pkg.sv
// Shared constants and helpers for the narrow-to-wide stream packer.
package stream_pkg;

    localparam int DEFAULT_IN_WIDTH = 8;
    localparam int DEFAULT_RATIO    = 4;
    // Upper bound on lanes any instance may use; lane_mask is cast down by the caller.
    localparam int MAX_LANES        = 32;

    typedef logic [$clog2(DEFAULT_RATIO)-1:0] lane_idx_t;

    function automatic logic [MAX_LANES-1:0] lane_mask(input int idx);
        return MAX_LANES'(1) << idx;
    endfunction

endpackage

// File: rtl/stream_upsizer.sv
// Packs RATIO narrow valid/ready beats into one registered wide word.
// in_last flushes a partial word early; out_keep marks which lanes were filled.
module stream_upsizer
    import stream_pkg::*;
#(
    parameter int IN_WIDTH  = DEFAULT_IN_WIDTH,
    parameter int RATIO     = DEFAULT_RATIO,
    localparam int OUT_WIDTH = IN_WIDTH * RATIO
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic [RATIO-1:0]     out_keep,
    output logic                 out_last
);

    localparam int CNT_W = $clog2(RATIO);

    logic [CNT_W-1:0]     cnt;
    logic [OUT_WIDTH-1:0] acc_data;
    logic [RATIO-1:0]     acc_keep;

    logic                 in_fire;
    logic                 out_fire;
    logic                 completing;
    logic [RATIO-1:0]     lane_sel;
    logic [OUT_WIDTH-1:0] merged;

    // A new beat can enter whenever the output register is empty or draining now.
    assign in_ready   = !out_valid || out_ready;
    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign completing = in_fire && ((cnt == CNT_W'(RATIO - 1)) || in_last);

    always_comb begin
        lane_sel = RATIO'(lane_mask(int'(cnt)));
        merged   = acc_data;
        for (int i = 0; i < RATIO; i++) begin
            if (lane_sel[i]) begin
                merged[i*IN_WIDTH +: IN_WIDTH] = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            acc_data  <= '0;
            acc_keep  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
        end else begin
            // Drain first; a completing beat below overrides this so there is no bubble.
            if (out_fire) begin
                out_valid <= 1'b0;
            end
            if (in_fire) begin
                if (completing) begin
                    out_valid <= 1'b1;
                    out_data  <= merged;
                    out_keep  <= acc_keep | lane_sel;
                    out_last  <= in_last;
                    acc_data  <= '0;
                    acc_keep  <= '0;
                    cnt       <= '0;
                end else begin
                    acc_data  <= merged;
                    acc_keep  <= acc_keep | lane_sel;
                    cnt       <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_upsizer.sv
// Bench for stream_upsizer: directed vector table, hand-written corner sequences,
// and random traffic checked against a beat-queue packing model.
module tb_stream_upsizer;

    localparam int IN_W  = 8;
    localparam int RATIO = 4;
    localparam int OUT_W = IN_W * RATIO;
    localparam int EW    = OUT_W + RATIO + 1;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [RATIO-1:0] out_keep;
    logic             out_last;

    stream_upsizer #(.IN_WIDTH(IN_W), .RATIO(RATIO)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    // Beats of the word being built; a word is emitted on RATIO beats or on last.
    logic [IN_W-1:0] lanes[$];
    logic [EW-1:0]   exp_q[$];
    logic            stall_prev = 1'b0;
    logic [EW-1:0]   held;

    always @(negedge clk) begin
        if (rst) begin
            lanes.delete();
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_hold", {out_valid, out_last, out_keep, out_data}, {1'b1, held});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_word: got %0h expected none at %0t", out_data, $time);
                end else begin
                    check("sb_word", {out_last, out_keep, out_data}, exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                lanes.push_back(in_data);
                if (in_last || lanes.size() == RATIO) begin
                    logic [OUT_W-1:0] w;
                    logic [RATIO-1:0] k;
                    w = '0;
                    k = '0;
                    foreach (lanes[i]) begin
                        w[i*IN_W +: IN_W] = lanes[i];
                        k[i] = 1'b1;
                    end
                    exp_q.push_back({in_last, k, w});
                    lanes.delete();
                end
            end
            stall_prev = out_valid && !out_ready;
            held       = {out_last, out_keep, out_data};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [IN_W-1:0] d, input logic l, input logic r);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic v, input logic [OUT_W-1:0] d,
                             input logic [RATIO-1:0] k, input logic l);
        check({name, "_valid"}, out_valid, v);
        check({name, "_data"},  out_data,  d);
        check({name, "_keep"},  out_keep,  k);
        check({name, "_last"},  out_last,  l);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic             iv;
        logic [IN_W-1:0]  d;
        logic             il;
        logic             ordy;
        logic             e_ir;
        logic             e_ov;
        logic [OUT_W-1:0] e_d;
        logic [RATIO-1:0] e_k;
        logic             e_l;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic iv, input logic [IN_W-1:0] d, input logic il,
                                input logic ordy, input logic e_ir, input logic e_ov,
                                input logic [OUT_W-1:0] e_d, input logic [RATIO-1:0] e_k,
                                input logic e_l);
        vec_t v;
        v.iv = iv; v.d = d; v.il = il; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_d = e_d; v.e_k = e_k; v.e_l = e_l;
        return v;
    endfunction

    initial begin
        logic took;

        // full word, output valid for one cycle
        vecs.push_back(mk(1, 8'h11, 0, 1, 1, 0, 32'h0,        4'h0, 0));
        vecs.push_back(mk(1, 8'h22, 0, 1, 1, 0, 32'h0,        4'h0, 0));
        vecs.push_back(mk(1, 8'h33, 0, 1, 1, 0, 32'h0,        4'h0, 0));
        vecs.push_back(mk(1, 8'h44, 0, 1, 1, 1, 32'h44332211, 4'hF, 0));
        vecs.push_back(mk(0, 8'h00, 0, 1, 1, 0, 32'h44332211, 4'hF, 0));
        // early flush, then next beat lands in lane 0
        vecs.push_back(mk(1, 8'hAA, 0, 1, 1, 0, 32'h44332211, 4'hF, 0));
        vecs.push_back(mk(1, 8'hBB, 1, 1, 1, 1, 32'h0000BBAA, 4'h3, 1));
        vecs.push_back(mk(1, 8'hCC, 0, 1, 1, 0, 32'h0000BBAA, 4'h3, 1));
        vecs.push_back(mk(1, 8'hDD, 1, 1, 1, 1, 32'h0000DDCC, 4'h3, 1));
        // last on lane 0 while the previous word drains: no bubble
        vecs.push_back(mk(1, 8'hEE, 1, 1, 1, 1, 32'h000000EE, 4'h1, 1));
        vecs.push_back(mk(0, 8'h00, 0, 1, 1, 0, 32'h000000EE, 4'h1, 1));
        // backpressure: out_ready low does not block an empty output stage
        vecs.push_back(mk(1, 8'h01, 0, 0, 1, 0, 32'h000000EE, 4'h1, 1));
        vecs.push_back(mk(1, 8'h02, 0, 0, 1, 0, 32'h000000EE, 4'h1, 1));
        vecs.push_back(mk(1, 8'h03, 0, 0, 1, 0, 32'h000000EE, 4'h1, 1));
        vecs.push_back(mk(1, 8'h04, 0, 0, 1, 1, 32'h04030201, 4'hF, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1, 8'h05, 0, 0, 0, 1, 32'h04030201, 4'hF, 0));
        vecs.push_back(mk(1, 8'h05, 0, 1, 1, 0, 32'h04030201, 4'hF, 0));
        vecs.push_back(mk(1, 8'h06, 0, 1, 1, 0, 32'h04030201, 4'hF, 0));
        vecs.push_back(mk(1, 8'h07, 0, 1, 1, 0, 32'h04030201, 4'hF, 0));
        vecs.push_back(mk(1, 8'h08, 0, 1, 1, 1, 32'h08070605, 4'hF, 0));
        vecs.push_back(mk(0, 8'h00, 0, 1, 1, 0, 32'h08070605, 4'hF, 0));

        // reset held two cycles with in_valid high
        rst = 1'b1;
        drive(1, 8'h55, 0, 1);
        step();
        step();
        rst = 1'b0;
        drive(0, 8'h00, 0, 1);
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check_out("rst", 0, 32'h0, 4'h0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].d, vecs[i].il, vecs[i].ordy);
            #1;
            check($sformatf("tbl%0d_in_ready", i), in_ready, vecs[i].e_ir);
            step();
            check_out($sformatf("tbl%0d", i), vecs[i].e_ov, vecs[i].e_d, vecs[i].e_k, vecs[i].e_l);
        end

        // back-to-back: in_ready never drops, word every 4 beats
        for (int i = 1; i <= 8; i++) begin
            drive(1, 8'(i), 0, 1);
            #1;
            check("b2b_in_ready", in_ready, 1'b1);
            step();
            check("b2b_valid", out_valid, (i % 4) == 0);
            if (i == 4) check("b2b_word0", out_data, 32'h04030201);
            if (i == 8) check("b2b_word1", out_data, 32'h08070605);
        end
        drive(0, 8'h00, 0, 1);
        step();

        // reset mid-word discards the partial accumulation
        drive(1, 8'hDE, 0, 1);
        step();
        drive(1, 8'hAD, 0, 1);
        step();
        rst = 1'b1;
        drive(1, 8'hFF, 0, 1);
        step();
        rst = 1'b0;
        drive(0, 8'h00, 0, 1);
        #1;
        check_out("midrst", 0, 32'h0, 4'h0, 0);
        for (int i = 1; i <= 4; i++) begin
            drive(1, 8'(i), 0, 1);
            step();
        end
        check_out("midrst_word", 1, 32'h04030201, 4'hF, 0);
        drive(0, 8'h00, 0, 1);
        step();

        // random traffic; a beat is held until accepted
        took = 1'b1;
        for (int k = 0; k < 600; k++) begin
            if (!in_valid || took) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = 8'($urandom);
                in_last  = ($urandom_range(0, 5) == 0);
            end
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            took = in_valid && in_ready;
            step();
        end

        // drain
        drive(0, 8'h00, 0, 1);
        repeat (4) step();
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
